// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryptor: one inverse round per clock, round keys derived on the fly,
// with an optional cache of the last expanded round-10 key to skip forward expansion.
module aes_decrypt_iter #(
    parameter bit KEY_CACHE = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ciphertext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plaintext,
    output logic         busy
);
    // state  | meaning
    // IDLE   | waiting for a ciphertext/key pair
    // KEXP   | forward key expansion, rounds 1..10
    // LOAD10 | cache hit: initial AddRoundKey with cached rk10
    // ROUND  | inverse rounds 9..0, key walked backwards
    // DONE   | plaintext held until taken
    typedef enum logic [2:0] {IDLE, KEXP, LOAD10, ROUND, DONE} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        r = a;
        for (int i = 0; i < 6; i++) r = gmul(gmul(r, r), a);
        return gmul(r, r);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        return gf_inv({y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        int src;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = 4 * ((c + 4 - r) % 4) + r;
                o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*src -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

    state_t        fsm_q;
    logic [3:0]    cnt_q;
    logic [127:0]  ct_q, key_q, rk_q, st_q, pt_q, cache_rk_q, cache_key_q;
    logic          cache_vld_q, in_ready_q, out_valid_q;

    logic [31:0]   w0, w1, w2, w3, sub_in, t_word;
    logic [3:0]    rc_idx;
    logic [127:0]  rk_fwd, rk_inv, dec_ark, st_round;
    logic          is_kexp, cache_hit;

    // One SubWord/RotWord unit serves both the forward and the inverse key step.
    assign {w0, w1, w2, w3} = rk_q;
    assign is_kexp  = (fsm_q == KEXP);
    assign sub_in   = is_kexp ? w3 : (w3 ^ w2);
    assign rc_idx   = is_kexp ? cnt_q : (cnt_q + 4'd1);
    assign t_word   = sub_rot_word(sub_in) ^ {rcon(rc_idx), 24'h000000};
    assign rk_fwd   = {w0 ^ t_word, w1 ^ w0 ^ t_word, w2 ^ w1 ^ w0 ^ t_word, w3 ^ w2 ^ w1 ^ w0 ^ t_word};
    assign rk_inv   = {w0 ^ t_word, w1 ^ w0, w2 ^ w1, w3 ^ w2};
    assign dec_ark  = inv_shift_sub(st_q) ^ rk_inv;
    assign st_round = inv_mix_columns(dec_ark);
    assign cache_hit = (KEY_CACHE != 1'b0) && cache_vld_q && (key == cache_key_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            cnt_q       <= '0;
            ct_q        <= '0;
            key_q       <= '0;
            rk_q        <= '0;
            st_q        <= '0;
            pt_q        <= '0;
            cache_rk_q  <= '0;
            cache_key_q <= '0;
            cache_vld_q <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        ct_q       <= ciphertext;
                        key_q      <= key;
                        in_ready_q <= 1'b0;
                        if (cache_hit) begin
                            rk_q  <= cache_rk_q;
                            fsm_q <= LOAD10;
                        end else begin
                            rk_q  <= key;
                            cnt_q <= 4'd1;
                            fsm_q <= KEXP;
                        end
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                KEXP: begin
                    rk_q <= rk_fwd;
                    if (cnt_q == 4'd10) begin
                        st_q        <= ct_q ^ rk_fwd;
                        cache_rk_q  <= rk_fwd;
                        cache_key_q <= key_q;
                        cache_vld_q <= 1'b1;
                        cnt_q       <= 4'd9;
                        fsm_q       <= ROUND;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                LOAD10: begin
                    st_q  <= ct_q ^ rk_q;
                    cnt_q <= 4'd9;
                    fsm_q <= ROUND;
                end
                ROUND: begin
                    rk_q <= rk_inv;
                    if (cnt_q == 4'd0) begin
                        pt_q        <= dec_ark;
                        out_valid_q <= 1'b1;
                        fsm_q       <= DONE;
                    end else begin
                        st_q  <= st_round;
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        fsm_q       <= IDLE;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign plaintext = pt_q;
    assign busy      = (fsm_q != IDLE);
endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Directed bench for aes_decrypt_iter: FIPS-197 vectors, latency, cache, backpressure and reset.
module tb_aes_decrypt_iter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [127:0] ciphertext, key;
    logic         iv0, iv1, ordy0, ordy1;
    logic         ir0, ir1, ov0, ov1, busy0, busy1;
    logic [127:0] pt0, pt1;

    int ntests = 0;
    int nfail  = 0;

    localparam logic [127:0] K_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_A = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P_A = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C_B = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P_B = 128'h3243f6a8885a308d313198a2e0370734;

    aes_decrypt_iter #(.KEY_CACHE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0),
        .ciphertext(ciphertext), .key(key), .out_valid(ov0), .out_ready(ordy0),
        .plaintext(pt0), .busy(busy0)
    );

    aes_decrypt_iter #(.KEY_CACHE(1'b0)) dut_nc (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .ciphertext(ciphertext), .key(key), .out_valid(ov1), .out_ready(ordy1),
        .plaintext(pt1), .busy(busy1)
    );

    function automatic logic rdy(input bit sel);
        return sel ? ir1 : ir0;
    endfunction
    function automatic logic ovf(input bit sel);
        return sel ? ov1 : ov0;
    endfunction
    function automatic logic bsy(input bit sel);
        return sel ? busy1 : busy0;
    endfunction
    function automatic logic [127:0] ptf(input bit sel);
        return sel ? pt1 : pt0;
    endfunction

    task automatic set_iv(input bit sel, input logic v);
        if (sel) iv1 = v; else iv0 = v;
    endtask
    task automatic set_or(input bit sel, input logic v);
        if (sel) ordy1 = v; else ordy0 = v;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic chk1(input string tag, input logic obs, input logic exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask
    task automatic chk_int(input string tag, input int obs, input int exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input bit sel, input string tag);
        int w;
        w = 0;
        @(negedge clk);
        while (!rdy(sel) && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk1({tag, "_ready"}, rdy(sel), 1'b1);
    endtask

    // Accept one pair, count edges until out_valid, check busy/in_ready on the way.
    task automatic send(input bit sel, input logic [127:0] c, input logic [127:0] k,
                        input bit noise, input int exp_lat, input string tag);
        int  lat;
        logic bad;
        wait_ready(sel, tag);
        ciphertext = c;
        key        = k;
        set_iv(sel, 1'b1);
        @(posedge clk);
        #1;
        set_iv(sel, 1'b0);
        lat = 0;
        bad = rdy(sel) || !bsy(sel);
        while (!ovf(sel) && lat < 60) begin
            if (noise) begin
                ciphertext = {$urandom, $urandom, $urandom, $urandom};
                key        = {$urandom, $urandom, $urandom, $urandom};
                set_iv(sel, lat[0]);
            end
            @(posedge clk);
            #1;
            lat++;
            if (rdy(sel) || !bsy(sel)) bad = 1'b1;
        end
        set_iv(sel, 1'b0);
        chk_int({tag, "_latency"}, lat, exp_lat);
        chk1({tag, "_busy_hold"}, bad, 1'b0);
    endtask

    task automatic take(input bit sel, input logic [127:0] exp_pt, input string tag);
        chk({tag, "_plaintext"}, ptf(sel), exp_pt);
        set_or(sel, 1'b1);
        @(posedge clk);
        #1;
        set_or(sel, 1'b0);
        chk1({tag, "_ov_drop"}, ovf(sel), 1'b0);
        chk1({tag, "_ir_back"}, rdy(sel), 1'b1);
        chk1({tag, "_idle"}, bsy(sel), 1'b0);
    endtask

    initial begin
        logic bad;
        rst_n = 1'b0;
        ciphertext = '0;
        key = '0;
        iv0 = 1'b0; iv1 = 1'b0; ordy0 = 1'b0; ordy1 = 1'b0;
        #22;
        chk1("rst_in_ready", ir0, 1'b0);
        chk1("rst_out_valid", ov0, 1'b0);
        chk("rst_plaintext", pt0, 128'h0);
        chk1("rst_busy", busy0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        send(0, C_A, K_A, 0, 20, "a_miss");
        take(0, P_A, "a_miss");

        send(0, C_A, K_A, 0, 11, "a_hit");
        take(0, P_A, "a_hit");

        send(0, C_B, K_B, 0, 20, "b_miss");
        take(0, P_B, "b_miss");

        send(0, C_B, K_B, 0, 11, "b_bp");
        bad = 1'b0;
        repeat (7) begin
            @(posedge clk);
            #1;
            if (pt0 !== P_B || ov0 !== 1'b1 || ir0 !== 1'b0) bad = 1'b1;
        end
        chk1("bp_stable", bad, 1'b0);
        take(0, P_B, "b_bp");

        send(0, C_A, K_A, 1, 20, "noise");
        take(0, P_A, "noise");
        @(negedge clk);
        chk1("noise_no_extra_accept", busy0, 1'b0);

        // Key B gets cached at edge 10; reset at edge 15 must throw the cache away.
        wait_ready(0, "mid_rst");
        ciphertext = C_B;
        key = K_B;
        iv0 = 1'b1;
        @(posedge clk);
        #1;
        iv0 = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk1("mid_rst_out_valid", ov0, 1'b0);
        chk("mid_rst_plaintext", pt0, 128'h0);
        chk1("mid_rst_busy", busy0, 1'b0);
        chk1("mid_rst_in_ready", ir0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        send(0, C_B, K_B, 0, 20, "post_rst");
        take(0, P_B, "post_rst");

        send(1, C_A, K_A, 0, 20, "nc_first");
        take(1, P_A, "nc_first");
        send(1, C_A, K_A, 0, 20, "nc_second");
        take(1, P_A, "nc_second");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
